shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential unsigned WIDTH x WIDTH multiplier built on the team's ripple adder.
//  Consumes one adder result per cycle (shift-and-add) and produces a 2*WIDTH-bit product.
//  Sits directly downstream of the WIDTH-bit adder: drives its operands, registers its sum/carry.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  8  operand width; product is 2*WIDTH bits; WIDTH >= 2
// PORTS
//  clk        input   1          single clock, rising edge
//  rst_n      input   1          asynchronous, active-low reset
//  in_valid   input   1          operand pair a/b valid
//  in_ready   output  1          block can accept operands (IDLE only)
//  a          input   WIDTH      multiplicand, sampled at accept
//  b          input   WIDTH      multiplier, sampled at accept
//  out_valid  output  1          product valid (DONE state)
//  out_ready  input   1          consumer takes product
//  product    output  2*WIDTH    a*b, held stable while out_valid=1
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, product=0, all internal regs=0.
//  - Internal regs: mcand[WIDTH], acc[WIDTH], mq[WIDTH], cnt[$clog2(WIDTH)].
//  - FSM states: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
//  - IDLE: on edge with in_valid=1: mcand<=a, mq<=b, acc<=0, cnt<=0, ->RUN. Else stay.
//  - RUN, every cycle: adder operands = acc and (mq[0] ? mcand : 0); sum[WIDTH], cout.
//      {acc,mq} <= {cout, sum, mq[WIDTH-1:1]}  (2*WIDTH+1 bits shifted right by 1; cout becomes acc MSB).
//      cnt<=cnt+1; on the edge where cnt==WIDTH-1: ->DONE, product<={acc_next,mq_next}.
//  - Latency: accept at edge N -> out_valid=1 after edge N+WIDTH (8 RUN cycles for WIDTH=8).
//  - No overflow possible: product width 2*WIDTH exact; carry never lost (absorbed into acc MSB).
//  - DONE: product and out_valid held while out_ready=0 (backpressure, indefinite).
//      On edge with out_ready=1: out_valid<=0, ->IDLE. No new accept in same cycle
//      (in_ready=0 in DONE); next accept earliest one cycle later. Throughput: 1 per WIDTH+2 cycles.
//  - in_valid ignored in RUN/DONE; a/b changes after accept do not affect the result.
//  - Reset mid-RUN or mid-DONE: immediate abort, result discarded, outputs to reset values.
//  - product retains last value in IDLE/RUN (not cleared); only meaningful when out_valid=1.
// CONFIGURATION
//  EARLY_TERM_EN defined:
//    - At accept, if a==0 or b==0: skip RUN, go IDLE->DONE directly, product<=0.
//      out_valid=1 after edge N+1. Nonzero operands behave exactly as without the macro.
//  EARLY_TERM_EN undefined:
//    - All operand pairs take the full WIDTH RUN cycles, including zeros.
// TESTING
//  - a=13,b=11, out_ready=1 -> product=143 (0x008F), out_valid rises 8 cycles after accept, 1-cycle pulse.
//  - a=255,b=255 -> product=65025 (0xFE01); checks carry into acc MSB every cycle.
//  - a=0,b=200 -> product=0; latency 8 cycles without EARLY_TERM_EN, 1 cycle with it.
//  - a=200,b=3, out_ready=0 for 5 cycles after out_valid -> product=600 (0x0258) stable,
//    in_ready=0 throughout; drop out_ready->1 -> IDLE next edge, in_ready=1.
//  - Accept a=100,b=100, assert rst_n=0 after 3 RUN cycles -> out_valid=0, in_ready=1 at once;
//    then a=7,b=9 -> product=63 with normal latency.
//  - Exhaustive: all 65536 (a,b) pairs back-to-back, in_valid held high, out_ready=1 -> product==a*b every time.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier around a ripple adder, valid/ready on both sides.
// Optional macro EARLY_TERM_EN: a zero operand skips the RUN phase and completes with product 0.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, stateNext;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     mq;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   productReg;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sumFull;
  logic [WIDTH-1:0]     accNext;
  logic [WIDTH-1:0]     mqNext;
  logic                 lastStep;

  function automatic logic [WIDTH:0] rippleAdd(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] s;
    logic             c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // One shift-and-add step: the adder carry lands in the accumulator MSB, so nothing is lost.
  assign addend   = mq[0] ? mcand : '0;
  assign sumFull  = rippleAdd(acc, addend);
  assign accNext  = sumFull[WIDTH:1];
  assign mqNext   = {sumFull[0], mq[WIDTH-1:1]};
  assign lastStep = (state == RUN) && (cnt == CW'(WIDTH - 1));

`ifdef EARLY_TERM_EN
  logic zeroOp;
  assign zeroOp = (a == '0) || (b == '0);
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef EARLY_TERM_EN
          stateNext = zeroOp ? DONE : RUN;
`else
          stateNext = RUN;
`endif
        end
      end
      RUN:     if (lastStep) stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mcand      <= '0;
      acc        <= '0;
      mq         <= '0;
      cnt        <= '0;
      productReg <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cnt   <= '0;
`ifdef EARLY_TERM_EN
            if (zeroOp) productReg <= '0;
`endif
          end
        end
        RUN: begin
          acc <= accNext;
          mq  <= mqNext;
          cnt <= cnt + CW'(1);
          if (lastStep) productReg <= {accNext, mqNext};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = productReg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: reference products and latencies from plain arithmetic,
// monitor pops and compares on each out_valid rise, with random backpressure and operand churn.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   product;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  typedef struct {
    longint prod;
    int     riseCyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } pair_t;

  exp_t  sb[$];
  pair_t pend[$];
  int    nChecks = 0;
  int    nFail   = 0;
  int    cyc     = 0;
  int    nDone   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef EARLY_TERM_EN
    if (x == 0 || y == 0) return 1;
`endif
    return W;
  endfunction

  // Called at a negedge with in_ready=1: the next posedge accepts.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    e.prod    = longint'(x) * longint'(y);
    e.riseCyc = cyc + 1 + latency(x, y);
    sb.push_back(e);
  endtask

  task automatic pickPair(output logic [W-1:0] x, output logic [W-1:0] y);
    pair_t p;
    int r;
    if (pend.size() > 0) begin
      p = pend.pop_front();
      x = p.x;
      y = p.y;
    end else begin
      r = $urandom_range(0, 9);
      x = (r == 0) ? '0 : (r == 1) ? '1 : W'($urandom);
      r = $urandom_range(0, 9);
      y = (r == 0) ? '0 : (r == 1) ? '1 : W'($urandom);
    end
  endtask

  task automatic runOps(input int n, input int bp, input bit burst);
    int issued = 0;
    int target = nDone + n;
    int guard  = 0;
    logic [W-1:0] x, y;
    while ((issued < n || nDone < target) && guard < n * 60 + 100) begin
      @(negedge clk);
      guard++;
      out_ready = ($urandom_range(0, 99) >= bp);
      if (issued < n && in_ready && (burst || $urandom_range(0, 3) != 0)) begin
        pickPair(x, y);
        issue(x, y);
        issued++;
      end else begin
        a        = W'($urandom);
        b        = W'($urandom);
        in_valid = in_ready ? 1'b0 : (burst ? 1'b1 : 1'($urandom_range(0, 1)));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (issued < n || nDone < target)
      chk("runOpsTimeout", nDone, target);
  endtask

  // Monitor: one observation per clock, 1 time unit after the rising edge.
  initial begin : monitor
    bit             prevOv;
    logic [2*W-1:0] held;
    exp_t           e;
    prevOv = 1'b0;
    held   = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        prevOv = 1'b0;
      end else begin
        if (prevOv && out_ready) begin
          chk("validDropAfterTake", out_valid, 0);
          nDone++;
        end else if (prevOv) begin
          chk("heldValid", out_valid, 1);
          chk("heldProduct", product, held);
        end
        if (out_valid) chk("inReadyLowInDone", in_ready, 0);
        if (out_valid && !prevOv) begin
          if (sb.size() == 0) begin
            chk("unexpectedOutput", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("product", product, e.prod);
            chk("latency", cyc, e.riseCyc);
          end
        end
        prevOv = out_valid;
        held   = product;
      end
    end
  end

  initial begin : stim
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstInReady", in_ready, 1);
    chk("rstOutValid", out_valid, 0);
    chk("rstProduct", product, 0);
    rst_n = 1'b1;

    // Directed corner products with no backpressure.
    pend.push_back('{x: 8'd13,  y: 8'd11});
    pend.push_back('{x: 8'd255, y: 8'd255});
    pend.push_back('{x: 8'd0,   y: 8'd200});
    pend.push_back('{x: 8'd200, y: 8'd0});
    pend.push_back('{x: 8'd1,   y: 8'd255});
    runOps(5, 0, 1'b0);

    // Held backpressure on 200*3.
    @(negedge clk);
    out_ready = 1'b0;
    issue(8'd200, 8'd3);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'd5;
    b = 8'd5;
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("bpSeen", out_valid, 1);
    repeat (5) begin
      chk("bpProduct", product, 600);
      chk("bpInReady", in_ready, 0);
      chk("bpValid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bpDrop", out_valid, 0);
    chk("bpIdle", in_ready, 1);

    // Abort 100*100 after three RUN cycles.
    @(negedge clk);
    issue(8'd100, 8'd100);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abortOutValid", out_valid, 0);
    chk("abortInReady", in_ready, 1);
    chk("abortProduct", product, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pend.push_back('{x: 8'd7, y: 8'd9});
    runOps(1, 0, 1'b0);

    // Randomized traffic: gaps and backpressure, then back-to-back bursts.
    runOps(300, 30, 1'b0);
    runOps(200, 0, 1'b1);
    runOps(100, 60, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboardEmpty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
